// File: rtl/disp_bcd_ctrl.sv
// -----------------------------------------------------------------------------
// disp_bcd_ctrl
// Converts a 14-bit unsigned binary value into four BCD display digits using a
// sequential shift-and-add-3 (double dabble) engine. Values above 9999 skip the
// conversion and display 9,9,9,9 with the ovf flag set. Leading zero digits can
// optionally be replaced by a blank code.
//
// Ports
//   clk         : single clock, rising edge active
//   reset       : asynchronous, active-high reset
//   in_value    : binary value to display (14 bits)
//   in_valid    : in_value is valid this cycle
//   in_ready    : block accepts a value this cycle (state IDLE)
//   split_nr_0  : ones digit
//   split_nr_1  : tens digit
//   split_nr_2  : hundreds digit
//   split_nr_3  : thousands digit
//   busy        : conversion in progress (state not IDLE)
//   done        : one-cycle pulse, digit outputs just updated
//   ovf         : last accepted value exceeded 9999
// -----------------------------------------------------------------------------
module disp_bcd_ctrl #(
  parameter bit         BLANK_LEADING = 1'b1,
  parameter logic [3:0] BLANK_CODE    = 4'hF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [13:0] in_value,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [3:0]  split_nr_0,
  output logic [3:0]  split_nr_1,
  output logic [3:0]  split_nr_2,
  output logic [3:0]  split_nr_3,
  output logic        busy,
  output logic        done,
  output logic        ovf
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } state_t;

  state_t      state_r;
  state_t      state_s;
  logic [15:0] bcd_r;
  logic [13:0] bin_r;
  logic [3:0]  cnt_r;
  logic        ovf_pend_r;
  logic [15:0] bcd_adj_s;

  // Add 3 to every BCD nibble that is 5 or more, so the following left shift
  // carries correctly into the next decimal digit.
  function automatic logic [15:0] dabble_adj(input logic [15:0] bcd);
    logic [15:0] adj;
    adj = bcd;
    for (int i = 0; i < 4; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end else begin
        adj[4*i +: 4] = bcd[4*i +: 4];
      end
    end
    return adj;
  endfunction

  // Replace zero digits above the most significant nonzero digit with the
  // blank code; the ones digit is always shown.
  function automatic logic [15:0] blank_digits(input logic [15:0] bcd);
    logic [15:0] res;
    logic        leading;
    res     = bcd;
    leading = 1'b1;
    for (int i = 3; i >= 1; i--) begin
      if ((BLANK_LEADING == 1'b1) && leading && (bcd[4*i +: 4] == 4'd0)) begin
        res[4*i +: 4] = BLANK_CODE;
      end else begin
        res[4*i +: 4] = bcd[4*i +: 4];
        leading       = 1'b0;
      end
    end
    return res;
  endfunction

  assign in_ready  = (state_r == IDLE);
  assign busy      = (state_r != IDLE);
  assign bcd_adj_s = dabble_adj(bcd_r);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic: in-range values take 14 shifts, overflow goes straight
  // to LATCH.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          if (in_value > 14'd9999) begin
            state_s = LATCH;
          end else begin
            state_s = SHIFT;
          end
        end else begin
          state_s = IDLE;
        end
      end
      SHIFT: begin
        // cnt_r == 13 means this edge performs the 14th shift.
        if (cnt_r == 4'd13) begin
          state_s = LATCH;
        end else begin
          state_s = SHIFT;
        end
      end
      LATCH:   state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Conversion datapath and registered display outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bcd_r      <= 16'h0000;
      bin_r      <= 14'd0;
      cnt_r      <= 4'd0;
      ovf_pend_r <= 1'b0;
      split_nr_0 <= 4'd0;
      split_nr_1 <= 4'd0;
      split_nr_2 <= 4'd0;
      split_nr_3 <= 4'd0;
      ovf        <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            bin_r <= in_value;
            cnt_r <= 4'd0;
            if (in_value > 14'd9999) begin
              bcd_r      <= 16'h9999;
              ovf_pend_r <= 1'b1;
            end else begin
              bcd_r      <= 16'h0000;
              ovf_pend_r <= 1'b0;
            end
          end
        end
        SHIFT: begin
          // {BCD, binary} shifted left by one after the add-3 correction.
          bcd_r <= {bcd_adj_s[14:0], bin_r[13]};
          bin_r <= {bin_r[12:0], 1'b0};
          cnt_r <= cnt_r + 4'd1;
        end
        LATCH: begin
          {split_nr_3, split_nr_2, split_nr_1, split_nr_0} <= blank_digits(bcd_r);
          ovf  <= ovf_pend_r;
          done <= 1'b1;
        end
        default: begin
          done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_disp_bcd_ctrl.sv
// -----------------------------------------------------------------------------
// tb_disp_bcd_ctrl
// Drives two instances (leading-zero blanking on and off) with the same
// stimulus. A reference model decides from edge counts when each value is
// accepted and pushes the expected display into a scoreboard; a monitor on the
// falling edge pops entries on their due cycle and compares every output.
// -----------------------------------------------------------------------------
module tb_disp_bcd_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [13:0] in_value = 14'd0;
  logic        in_valid = 1'b0;

  logic        in_ready, busy, done, ovf;
  logic [3:0]  s0, s1, s2, s3;
  logic        nb_ready, nb_busy, nb_done, nb_ovf;
  logic [3:0]  n0, n1, n2, n3;

  always #5 clk = ~clk;

  disp_bcd_ctrl dut (
    .clk(clk), .reset(reset), .in_value(in_value), .in_valid(in_valid),
    .in_ready(in_ready), .split_nr_0(s0), .split_nr_1(s1), .split_nr_2(s2),
    .split_nr_3(s3), .busy(busy), .done(done), .ovf(ovf)
  );

  disp_bcd_ctrl #(.BLANK_LEADING(1'b0), .BLANK_CODE(4'hF)) dut_nb (
    .clk(clk), .reset(reset), .in_value(in_value), .in_valid(in_valid),
    .in_ready(nb_ready), .split_nr_0(n0), .split_nr_1(n1), .split_nr_2(n2),
    .split_nr_3(n3), .busy(nb_busy), .done(nb_done), .ovf(nb_ovf)
  );

  typedef struct {
    int          due;
    logic [15:0] dig_b;
    logic [15:0] dig_n;
    logic        ovf;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          edge_n = 0;
  int          ready_edge = 0;
  logic [15:0] disp_b = 16'h0000;
  logic [15:0] disp_n = 16'h0000;
  logic        disp_ovf = 1'b0;

  function automatic logic [15:0] model_digits(input int v, input bit blank);
    logic [15:0] r;
    int p;
    if (v > 9999) return 16'h9999;
    r = 16'h0000;
    p = 1;
    for (int i = 0; i < 4; i++) begin
      if (blank && i > 0 && v < p) r[4*i +: 4] = 4'hF;
      else r[4*i +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at edge %0d", name, act, exp, edge_n);
    end
  endtask

  // Reference model: counts edges and decides acceptance from its own timing.
  initial begin : model_proc
    exp_t e;
    forever begin
      @(posedge clk);
      edge_n++;
      if (!reset && in_valid && edge_n >= ready_edge) begin
        e.ovf   = (int'(in_value) > 9999);
        e.dig_b = model_digits(int'(in_value), 1'b1);
        e.dig_n = model_digits(int'(in_value), 1'b0);
        e.due   = edge_n + (e.ovf ? 1 : 15);
        ready_edge = edge_n + (e.ovf ? 2 : 16);
        sb.push_back(e);
      end
    end
  end

  // Monitor: compares handshake, done pulse and displayed digits every cycle.
  initial begin : monitor_proc
    exp_t e;
    bit   exp_done;
    bit   exp_ready;
    forever begin
      @(negedge clk);
      exp_ready = (edge_n + 1 >= ready_edge);
      chk("in_ready", in_ready, exp_ready);
      chk("busy", busy, !exp_ready);
      chk("nb_in_ready", nb_ready, exp_ready);
      chk("nb_busy", nb_busy, !exp_ready);
      exp_done = (sb.size() > 0) && (sb[0].due == edge_n);
      chk("done", done, exp_done);
      chk("nb_done", nb_done, exp_done);
      if (exp_done) begin
        e        = sb.pop_front();
        disp_b   = e.dig_b;
        disp_n   = e.dig_n;
        disp_ovf = e.ovf;
      end
      chk("digits", {s3, s2, s1, s0}, disp_b);
      chk("nb_digits", {n3, n2, n1, n0}, disp_n);
      chk("ovf", ovf, disp_ovf);
      chk("nb_ovf", nb_ovf, disp_ovf);
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 40 && (sb.size() > 0 || edge_n + 1 < ready_edge); i++)
      @(negedge clk);
    chk("idle_timeout", sb.size(), 0);
  endtask

  task automatic send(input int v);
    @(negedge clk);
    in_value = 14'(v);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    sb.delete();
    disp_b = 16'h0000;
    disp_n = 16'h0000;
    disp_ovf = 1'b0;
    ready_edge = 0;
  endtask

  int directed[5] = '{42, 0, 9999, 12000, 5};

  initial begin
    apply_reset();
    repeat (2) @(negedge clk);
    chk("rst_digits", {s3, s2, s1, s0}, 16'h0000);
    chk("rst_done", done, 1'b0);
    chk("rst_ovf", ovf, 1'b0);
    chk("rst_ready", in_ready, 1'b1);

    // Accept on the first edge after reset release: 1234.
    reset = 1'b0;
    in_value = 14'd1234;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    wait_idle();

    foreach (directed[i]) begin
      send(directed[i]);
      wait_idle();
    end

    // in_valid held high with changing values: only accepting-edge values count.
    @(negedge clk);
    in_valid = 1'b1;
    repeat (60) begin
      in_value = 14'($urandom_range(0, 9999));
      @(negedge clk);
    end
    in_valid = 1'b0;
    wait_idle();

    // Asynchronous reset after the 7th shift of 4321.
    @(negedge clk);
    in_value = 14'd4321;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #2 apply_reset();
    #1;
    chk("midrst_digits", {s3, s2, s1, s0}, 16'h0000);
    chk("midrst_done", done, 1'b0);
    chk("midrst_ovf", ovf, 1'b0);
    chk("midrst_ready", in_ready, 1'b1);
    chk("midrst_busy", busy, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    send(4321);
    wait_idle();

    // Random values and gaps, including overflow values.
    repeat (30) begin
      repeat ($urandom_range(0, 20)) @(negedge clk);
      in_value = 14'($urandom_range(0, 16383));
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
    end
    wait_idle();
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/disp_bcd_ctrl.md
DISP_BCD_CTRL -- requirements
Module: disp_bcd_ctrl

Interface
REQ-001 SHALL provide parameter BLANK_LEADING, default 1: 1 = blank leading zero digits, 0 = show all digits.
REQ-002 SHALL provide parameter BLANK_CODE, default 4'hF: nibble driven on a blanked digit.
REQ-003 SHALL provide clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL provide reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL provide in_value  input  14  unsigned binary value to display.
REQ-006 SHALL provide in_valid  input  1  in_value is valid this cycle.
REQ-007 SHALL provide in_ready  output  1  block accepts a value this cycle.
REQ-008 SHALL provide split_nr_0..split_nr_3  output  4 each  displayed digits; split_nr_0 = ones, split_nr_3 = thousands.
REQ-009 SHALL provide busy  output  1  conversion in progress.
REQ-010 SHALL provide done  output  1  one-cycle pulse; digit outputs just updated.
REQ-011 SHALL provide ovf  output  1  last accepted value exceeded 9999.

Function
REQ-012 SHALL implement FSM states IDLE, SHIFT and LATCH.
REQ-013 SHALL drive in_ready = 1 exactly when state = IDLE, and busy = 1 exactly when state != IDLE.
REQ-014 SHALL accept a value on an edge where in_valid = 1 and in_ready = 1 (accepting edge E0); in_valid in any other state SHALL be ignored.
REQ-015 SHALL, at E0 with in_value <= 9999, capture in_value, clear the 16-bit BCD accumulator and the 4-bit iteration counter, and enter SHIFT.
REQ-016 SHALL, on each SHIFT edge, add 3 to every BCD nibble >= 5, then shift {BCD, binary} left by one bit, then increment the counter.
REQ-017 SHALL perform exactly 14 shifts (E1..E14), then enter LATCH.
REQ-018 SHALL, at E0 with in_value > 9999, enter LATCH directly with the accumulator forced to 9,9,9,9.
REQ-019 SHALL, at the LATCH edge, write the digit outputs from the accumulator, write ovf, assert done for the following cycle only, and return to IDLE.
REQ-020 SHALL therefore update digit outputs at E15 for in-range values and at E1 for overflowed values.
REQ-021 SHALL keep split_nr_* and ovf stable at all times except the LATCH edge.
REQ-022 SHALL, when BLANK_LEADING = 1, replace every zero digit above the most significant nonzero digit with BLANK_CODE.
REQ-023 SHALL never blank split_nr_0, so a value of 0 displays BLANK_CODE, BLANK_CODE, BLANK_CODE, 0 (split_nr_3..0).
REQ-024 SHALL apply blanking at the LATCH edge only.
REQ-025 SHALL set ovf = 1 when the captured value is > 9999 and 0 otherwise; ovf holds until the next LATCH.
REQ-026 SHALL allow a new value to be accepted in the same cycle that done = 1, because state is already IDLE.
REQ-027 SHALL sustain back-to-back conversions at a 16-cycle period for in-range values.

Reset
REQ-028 SHALL, while reset = 1, force state IDLE, split_nr_0..3 = 0, done = 0, ovf = 0, busy = 0, and clear the accumulator and counter; in_ready = 1.
REQ-029 SHALL, on reset during SHIFT or LATCH, abort the conversion, emit no done, and leave the digit outputs at 0.
REQ-030 SHALL accept in_valid on the first edge after reset deasserts.

Verification
REQ-031 SHALL cover: assert reset mid-run -> split_nr_3..0 = 0,0,0,0; ovf = 0; done = 0; in_ready = 1.
REQ-032 SHALL cover: BLANK_LEADING = 0, in_value = 1234 pulsed 1 cycle -> busy for 15 cycles; at E15 digits 1,2,3,4; done high for exactly 1 cycle; ovf = 0.
REQ-033 SHALL cover: BLANK_LEADING = 1, in_value = 42 -> digits F,F,4,2; then in_value = 0 -> F,F,F,0; then 9999 -> 9,9,9,9.
REQ-034 SHALL cover: in_value = 12000 -> at E1 digits 9,9,9,9, ovf = 1, done pulse; then 5 -> ovf = 0, digits F,F,F,5.
REQ-035 SHALL cover: in_valid held high with value changing during SHIFT -> only the E0 value is converted; the next value is accepted in the done cycle; outputs change only at LATCH edges.
REQ-036 SHALL cover: reset asserted asynchronously after the 7th shift of 4321 -> outputs immediately 0, no done; after release, 4321 reconverts to 4,3,2,1 at E15.
